next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
//  Next-PC generator sitting directly upstream of the fetch stage; drives its PCF_new input.
//  Direct-mapped branch target buffer (BTB) predicts taken branches/jumps at fetch time.
//  Accepts branch resolution from EX, detects mispredicts, redirects fetch and raises a flush.
//  BTB is trained on every resolved control-flow instruction.
// PARAMETERS
//  BTB_ENTRIES  16  number of BTB entries; power of two, >= 2; IDX_W = $clog2(BTB_ENTRIES)
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   asynchronous, active-high; clears all BTB state
//  PCF           in   32  current fetch PC
//  PCPlus4F      in   32  PCF + 4
//  ResolveE      in   1   EX holds a branch/jump being resolved this cycle (one-cycle pulse per instr)
//  PCE           in   32  PC of the resolving instruction
//  PCPlus4E      in   32  PCE + 4
//  TakenE        in   1   actual outcome (1 = taken; jumps always 1)
//  PCTargetE     in   32  actual target
//  PredTakenE    in   1   PredTakenF carried down the pipe with that instruction
//  PredTargetE   in   32  PCF_new value carried down the pipe with that instruction
//  PCF_new       out  32  next fetch PC
//  PredTakenF    out  1   prediction made for PCF this cycle
//  FlushE        out  1   mispredict: squash instructions in D and E
// BEHAVIOUR
//  - Lookup (combinational on PCF): idx = PCF[IDX_W+1:2], tag = PCF[31:IDX_W+2];
//    hit = valid[idx] & (tag_mem[idx] == tag). PCF[1:0] is ignored.
//  - MispredictE = ResolveE & ((TakenE != PredTakenE) | (TakenE & (PCTargetE != PredTargetE))).
//  - PCF_new priority: MispredictE -> (TakenE ? PCTargetE : PCPlus4E);
//    else PredTakenF -> target_mem[idx]; else PCPlus4F.
//  - FlushE = MispredictE (combinational, same cycle as the resolve).
//  - PredTakenF = hit & predict bit (see CONFIGURATION); forced 0 when MispredictE.
//  - Update at the rising edge when ResolveE = 1, using uidx/utag derived from PCE:
//    TakenE=1 -> valid=1, tag=utag, target=PCTargetE (allocate or overwrite).
//    TakenE=0 -> behaviour per CONFIGURATION. Updates are independent of MispredictE.
//  - Same-cycle lookup and update of one index: lookup uses pre-edge contents (no bypass).
//  - Targets are stored in full 32 bits; no wrap handling beyond natural 32-bit arithmetic upstream.
//  - Reset (async, any time): valid[*]=0, counters=2'b01; outputs then follow combinationally
//    (PCF=0 -> PCF_new=32'h4, PredTakenF=0, FlushE=0 with ResolveE=0).
//  - No stall input: fetch-side stall is applied by the fetch stage's enable; table state changes only on ResolveE.
// CONFIGURATION
//  Macro NPC_BHT_EN:
//   defined   : per-entry 2-bit saturating counter. Predict bit = ctr[1].
//               Allocate on taken with ctr=2'b10. Taken hit -> ctr+1 (sat 11); not-taken hit -> ctr-1 (sat 00).
//               Not-taken never clears valid; not-taken miss leaves the entry untouched.
//   undefined : no counters; predict bit = 1 (hit implies taken).
//               Not-taken resolve on a hit clears valid[uidx]; not-taken miss leaves the entry untouched.
// TESTING
//  1. Reset, PCF=0x0 -> PCF_new=0x4, PredTakenF=0, FlushE=0; all lookups miss.
//  2. Resolve PCE=0x40 taken to 0x100 with PredTakenE=0 -> FlushE=1, PCF_new=0x100 that cycle.
//     Later PCF=0x40 -> PredTakenF=1, PCF_new=0x100.
//  3. After step 2, resolve PCE=0x40 not taken with PredTakenE=1 -> FlushE=1, PCF_new=0x44.
//     Without NPC_BHT_EN the next PCF=0x40 misses; with it, ctr=01 and PredTakenF=0.
//  4. Aliasing, BTB_ENTRIES=16: train 0x40->0x100, then PCF=0x440 (same idx, different tag) -> miss, PCF_new=0x444.
//  5. Target mismatch: PredTakenE=1, PredTargetE=0x100, TakenE=1, PCTargetE=0x200 -> FlushE=1,
//     PCF_new=0x200; entry target becomes 0x200.
//  6. Assert reset mid-run after training -> all entries invalid immediately; PCF=0x40 -> PCF_new=0x44.

Source files
------------

// File: rtl/next_pc_unit_if.sv
// Signal bundle between the fetch/execute pipeline and the next-PC generator.
interface next_pc_unit_if;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        ResolveE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic        TakenE;
    logic [31:0] PCTargetE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic [31:0] PCF_new;
    logic        PredTakenF;
    logic        FlushE;

    modport master (
        output PCF, PCPlus4F, ResolveE, PCE, PCPlus4E, TakenE,
        output PCTargetE, PredTakenE, PredTargetE,
        input  PCF_new, PredTakenF, FlushE
    );

    modport slave (
        input  PCF, PCPlus4F, ResolveE, PCE, PCPlus4E, TakenE,
        input  PCTargetE, PredTakenE, PredTargetE,
        output PCF_new, PredTakenF, FlushE
    );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC generator with a direct-mapped BTB and EX-stage mispredict redirect.
// Optional 2-bit counter predictor per entry: define NPC_BHT_EN.
module next_pc_unit #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic          clk,
    input  logic          reset,
    next_pc_unit_if.slave npc
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];

    logic [IDX_W-1:0] fidx;
    logic [IDX_W-1:0] uidx;
    logic [TAG_W-1:0] ftag;
    logic [TAG_W-1:0] utag;
    logic             fhit;
    logic             uhit;
    logic             pred_bit;
    logic             pred_f;
    logic             mispredict;
    logic             entry_we;
    logic             valid_d;
    logic             unused_lsbs;

    assign fidx = npc.PCF[IDX_W+1:2];
    assign ftag = npc.PCF[31:IDX_W+2];
    assign uidx = npc.PCE[IDX_W+1:2];
    assign utag = npc.PCE[31:IDX_W+2];
    assign unused_lsbs = ^{npc.PCF[1:0], npc.PCE[1:0]};

    assign fhit = valid_q[fidx] && (tag_q[fidx] == ftag);
    assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

    assign mispredict = npc.ResolveE &&
        ((npc.TakenE != npc.PredTakenE) ||
         (npc.TakenE && (npc.PCTargetE != npc.PredTargetE)));

    assign pred_f = fhit && pred_bit && !mispredict;

    always_comb begin
        npc.FlushE     = mispredict;
        npc.PredTakenF = pred_f;
        npc.PCF_new    = npc.PCPlus4F;
        if (mispredict)
            npc.PCF_new = npc.TakenE ? npc.PCTargetE : npc.PCPlus4E;
        else if (pred_f)
            npc.PCF_new = target_q[fidx];
    end

    // Taken resolves (re)allocate; not-taken ones may only retire a hit.
    always_comb begin
        entry_we = npc.ResolveE && npc.TakenE;
        valid_d  = valid_q[uidx];
        if (npc.ResolveE) begin
            if (npc.TakenE)
                valid_d = 1'b1;
`ifndef NPC_BHT_EN
            else if (uhit)
                valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            valid_q <= '0;
        else if (npc.ResolveE)
            valid_q[uidx] <= valid_d;
    end

    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (entry_we) begin
            tag_q[uidx]    <= utag;
            target_q[uidx] <= npc.PCTargetE;
        end
    end

`ifdef NPC_BHT_EN
    logic [1:0] ctr_q [BTB_ENTRIES];
    logic [1:0] ctr_d;
    logic       ctr_we;

    always_comb begin
        ctr_d  = ctr_q[uidx];
        ctr_we = 1'b0;
        if (npc.ResolveE) begin
            if (!uhit) begin
                ctr_we = npc.TakenE;
                ctr_d  = 2'b10;
            end else begin
                ctr_we = 1'b1;
                if (npc.TakenE && ctr_q[uidx] != 2'b11)
                    ctr_d = ctr_q[uidx] + 2'd1;
                else if (!npc.TakenE && ctr_q[uidx] != 2'b00)
                    ctr_d = ctr_q[uidx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                ctr_q[i] <= 2'b01;
        end else if (ctr_we) begin
            ctr_q[uidx] <= ctr_d;
        end
    end

    assign pred_bit = ctr_q[fidx][1];
`else
    assign pred_bit = 1'b1;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed vectors, literal checks
// and a per-cycle comparison against a table-level BTB model.
`timescale 1ns/1ps
module tb_next_pc_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_en = 1'b0;

    next_pc_unit_if bus();

    next_pc_unit #(.BTB_ENTRIES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .npc   (bus)
    );

    always #5 clk = ~clk;

    // Model: per index remember the full branch PC, its target and a counter.
    bit          m_valid [16];
    logic [31:0] m_pc    [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          mi;
    bit          mh;

    function automatic int m_idx(logic [31:0] pc);
        return int'((pc >> 2) & 32'd15);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        int i = m_idx(pc);
        return m_valid[i] && ((m_pc[i] >> 6) == (pc >> 6));
    endfunction

    function automatic bit m_pred(logic [31:0] pc);
`ifdef NPC_BHT_EN
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
`else
        return m_hit(pc);
`endif
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
        end else if (bus.ResolveE) begin
            mi = m_idx(bus.PCE);
            mh = m_hit(bus.PCE);
            if (bus.TakenE) begin
                m_ctr[mi]   = mh ? ((m_ctr[mi] == 3) ? 3 : m_ctr[mi] + 1) : 2;
                m_valid[mi] = 1'b1;
                m_pc[mi]    = bus.PCE;
                m_tgt[mi]   = bus.PCTargetE;
            end else if (mh) begin
`ifdef NPC_BHT_EN
                m_ctr[mi] = (m_ctr[mi] == 0) ? 0 : m_ctr[mi] - 1;
`else
                m_valid[mi] = 1'b0;
`endif
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    bit          e_mis;
    bit          e_pt;
    logic [31:0] e_pc;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_mis = bus.ResolveE &&
                ((bus.TakenE != bus.PredTakenE) ||
                 (bus.TakenE && bus.PCTargetE != bus.PredTargetE));
            e_pt = !e_mis && m_pred(bus.PCF);
            if (e_mis)
                e_pc = bus.TakenE ? bus.PCTargetE : bus.PCE + 32'd4;
            else if (e_pt)
                e_pc = m_tgt[m_idx(bus.PCF)];
            else
                e_pc = bus.PCF + 32'd4;
            chk("model_pcf_new", bus.PCF_new, e_pc);
            chk("model_predtaken", {31'b0, bus.PredTakenF}, {31'b0, e_pt});
            chk("model_flush", {31'b0, bus.FlushE}, {31'b0, e_mis});
        end
    end

    task automatic drive(logic [31:0] pcf, bit res = 1'b0,
                         logic [31:0] pce = 32'h0, bit tk = 1'b0,
                         logic [31:0] tgt = 32'h0, bit ptk = 1'b0,
                         logic [31:0] ptgt = 32'h0);
        @(posedge clk);
        #1;
        bus.PCF         = pcf;
        bus.PCPlus4F    = pcf + 32'd4;
        bus.ResolveE    = res;
        bus.PCE         = pce;
        bus.PCPlus4E    = pce + 32'd4;
        bus.TakenE      = tk;
        bus.PCTargetE   = tgt;
        bus.PredTakenE  = ptk;
        bus.PredTargetE = ptgt;
        #3;
    endtask

    task automatic expect_out(string name, logic [31:0] npc, bit pt, bit fl);
        chk({name, "_pcf_new"}, bus.PCF_new, npc);
        chk({name, "_predtaken"}, {31'b0, bus.PredTakenF}, {31'b0, pt});
        chk({name, "_flush"}, {31'b0, bus.FlushE}, {31'b0, fl});
    endtask

    initial begin
        bus.PCF = 0; bus.PCPlus4F = 4; bus.ResolveE = 0;
        bus.PCE = 0; bus.PCPlus4E = 4; bus.TakenE = 0;
        bus.PCTargetE = 0; bus.PredTakenE = 0; bus.PredTargetE = 0;
        #1 reset = 1'b1;
        #1 expect_out("reset", 32'h4, 1'b0, 1'b0);
        cmp_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        drive(32'h0);
        expect_out("cold_miss", 32'h4, 1'b0, 1'b0);

        drive(32'h44, 1, 32'h40, 1, 32'h100, 0, 32'h44);
        expect_out("train_flush", 32'h100, 1'b0, 1'b1);
        drive(32'h40);
        expect_out("train_hit", 32'h100, 1'b1, 1'b0);

        drive(32'h100, 1, 32'h40, 0, 32'h100, 1, 32'h100);
        expect_out("nt_flush", 32'h44, 1'b0, 1'b1);
        drive(32'h40);
        expect_out("nt_after", 32'h44, 1'b0, 1'b0);

        drive(32'h44, 1, 32'h40, 1, 32'h100, 0, 32'h44);
        drive(32'h440);
        expect_out("alias_miss", 32'h444, 1'b0, 1'b0);
        drive(32'h40);
        expect_out("alias_orig", 32'h100, 1'b1, 1'b0);

        drive(32'h100, 1, 32'h40, 1, 32'h200, 1, 32'h100);
        expect_out("tgt_flush", 32'h200, 1'b0, 1'b1);
        drive(32'h40);
        expect_out("tgt_new", 32'h200, 1'b1, 1'b0);

        drive(32'h80, 1, 32'h80, 1, 32'h500, 1, 32'h500);
        expect_out("no_bypass", 32'h84, 1'b0, 1'b0);
        drive(32'h82);
        expect_out("lsb_ignored", 32'h500, 1'b1, 1'b0);
        drive(32'h40);
        expect_out("evicted", 32'h44, 1'b0, 1'b0);

        drive(32'h14, 1, 32'h10, 1, 32'h20, 0, 32'h14);
        drive(32'h10);
        expect_out("pre_reset", 32'h20, 1'b1, 1'b0);
        reset = 1'b1;
        #1 expect_out("async_reset", 32'h14, 1'b0, 1'b0);
        drive(32'h80);
        expect_out("in_reset", 32'h84, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(32'h10);
        expect_out("post_reset", 32'h14, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++)
            drive(32'h1000 + 32'((k % 6) * 4), 1'b1,
                  32'h1000 + 32'(((k * 5) % 6) * 4), (k % 3) != 0,
                  32'h2000 + 32'((k % 4) * 16), k[0], 32'h2000);
        for (int k = 0; k < 6; k++)
            drive(32'h1000 + 32'(k * 4));

        @(posedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
